// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-drive bundle for alu_arbiter.
// master: the two requesters plus the ALU; slave: the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
);
  logic             req0_valid;
  logic [OP_W-1:0]  req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [OP_W-1:0]  req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_sign;
  logic             rsp_zero;
  logic             rsp_dz;

  logic [OP_W-1:0]  alu_com;
  logic [WIDTH-1:0] alu_in0;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             alu_sign;
  logic             alu_zero;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    output alu_out, alu_carry, alu_sign, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_carry, rsp_sign, rsp_zero, rsp_dz,
    input  alu_com, alu_in0, alu_in1
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    input  alu_out, alu_carry, alu_sign, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_carry, rsp_sign, rsp_zero, rsp_dz,
    output alu_com, alu_in0, alu_in1
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-port sequencer in front of the shared ALU; traps DIV/MOD by
// zero locally and returns result plus the ALU's registered flags.
module alu_arbiter #(
  parameter int              WIDTH       = 32,
  parameter int              OP_W        = 4,
  parameter logic [OP_W-1:0] OP_THA_WORD = OP_W'(0),
  parameter logic [OP_W-1:0] OP_DIV      = OP_W'(4),
  parameter logic [OP_W-1:0] OP_MOD      = OP_W'(5)
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] FLAGS = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic             prio_reg;
  logic             owner_reg;
  logic [OP_W-1:0]  op_reg;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg;
  logic             carry_reg, sign_reg, zero_reg, dz_reg;

  logic             any_req;
  logic             grant;
  logic [OP_W-1:0]  sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             trap;
  logic             accept;
  logic             rsp_go;
  logic             alu_busy;

  // Contention goes to prio; a lone requester wins regardless of prio.
  assign any_req = bus.req0_valid | bus.req1_valid;
  assign grant   = (bus.req0_valid & bus.req1_valid) ? prio_reg : bus.req1_valid;
  assign sel_op  = grant ? bus.req1_op : bus.req0_op;
  assign sel_a   = grant ? bus.req1_a  : bus.req0_a;
  assign sel_b   = grant ? bus.req1_b  : bus.req0_b;
  assign trap    = ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b == '0);

  // Ready is gated by rst so it is low while reset is held, not only after.
  assign accept         = (state_reg == IDLE) && any_req && !rst;
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  assign bus.rsp0_valid = (state_reg == RESP) && !owner_reg;
  assign bus.rsp1_valid = (state_reg == RESP) && owner_reg;
  assign rsp_go         = (state_reg == RESP) &&
                          (owner_reg ? bus.rsp1_ready : bus.rsp0_ready);

  assign bus.rsp_result = result_reg;
  assign bus.rsp_carry  = carry_reg;
  assign bus.rsp_sign   = sign_reg;
  assign bus.rsp_zero   = zero_reg;
  assign bus.rsp_dz     = dz_reg;

  // Idle ALU sees a pass-through op with zero operands so its flags stay put.
  assign alu_busy    = (state_reg == EXEC) || (state_reg == FLAGS);
  assign bus.alu_com = alu_busy ? op_reg : OP_THA_WORD;
  assign bus.alu_in0 = alu_busy ? a_reg  : '0;
  assign bus.alu_in1 = alu_busy ? b_reg  : '0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = trap ? RESP : EXEC;
      EXEC:    state_next = FLAGS;
      FLAGS:   state_next = RESP;
      RESP:    if (rsp_go) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      prio_reg   <= 1'b0;
      owner_reg  <= 1'b0;
      op_reg     <= OP_THA_WORD;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      sign_reg   <= 1'b0;
      zero_reg   <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner_reg <= grant;
            op_reg    <= sel_op;
            a_reg     <= sel_a;
            b_reg     <= sel_b;
            if (trap) begin
              result_reg <= '0;
              dz_reg     <= 1'b1;
              carry_reg  <= 1'b0;
              sign_reg   <= 1'b0;
              zero_reg   <= 1'b0;
            end
          end
        end
        EXEC: begin
          result_reg <= bus.alu_out;
          dz_reg     <= 1'b0;
        end
        FLAGS: begin
          // Flags were registered inside the ALU on the EXEC edge.
          carry_reg <= bus.alu_carry;
          sign_reg  <= bus.alu_sign;
          zero_reg  <= bus.alu_zero;
        end
        RESP: begin
          if (rsp_go) prio_reg <= ~owner_reg;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU (sticky flags).
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int OP_W  = 4;
  localparam logic [OP_W-1:0] OP_THA = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_MUL = 4'd3;
  localparam logic [OP_W-1:0] OP_DIV = 4'd4;
  localparam logic [OP_W-1:0] OP_MOD = 4'd5;
  localparam logic [OP_W-1:0] OP_CMP = 4'd6;
  localparam logic [OP_W-1:0] OP_CGE = 4'd7;
  localparam logic [OP_W-1:0] OP_CGT = 4'd8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passes = 0;

  logic [WIDTH-1:0] alu_res;
  logic alu_c = 1'b0;
  logic alu_s = 1'b0;
  logic alu_z = 1'b0;
  logic watch_com = 1'b0;
  logic com_moved = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH), .OP_W(OP_W)) bus ();

  alu_arbiter #(
    .WIDTH(WIDTH), .OP_W(OP_W),
    .OP_THA_WORD(OP_THA), .OP_DIV(OP_DIV), .OP_MOD(OP_MOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ALU model: combinational result, flags registered only on compares.
  always_comb begin
    alu_res = bus.alu_in0;
    case (bus.alu_com)
      OP_ADD: alu_res = bus.alu_in0 + bus.alu_in1;
      OP_SUB: alu_res = bus.alu_in0 - bus.alu_in1;
      OP_MUL: alu_res = bus.alu_in0 * bus.alu_in1;
      OP_DIV: alu_res = (bus.alu_in1 != 0) ? bus.alu_in0 / bus.alu_in1 : '0;
      OP_MOD: alu_res = (bus.alu_in1 != 0) ? bus.alu_in0 % bus.alu_in1 : '0;
      default: alu_res = bus.alu_in0;
    endcase
  end
  assign bus.alu_out   = alu_res;
  assign bus.alu_carry = alu_c;
  assign bus.alu_sign  = alu_s;
  assign bus.alu_zero  = alu_z;

  always @(posedge clk) begin
    if (bus.alu_com == OP_CMP) begin
      alu_c <= bus.alu_in0 < bus.alu_in1;
      alu_s <= $signed(bus.alu_in0) < $signed(bus.alu_in1);
      alu_z <= bus.alu_in0 == bus.alu_in1;
    end else if (bus.alu_com == OP_CGT) begin
      alu_s <= !($signed(bus.alu_in0) > $signed(bus.alu_in1));
    end else if (bus.alu_com == OP_CGE) begin
      alu_s <= !($signed(bus.alu_in0) >= $signed(bus.alu_in1));
    end
    if (watch_com && bus.alu_com != OP_THA) com_moved <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int p, input logic v, input logic [OP_W-1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rv(input int p);
    return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  // Expects port p to be granted this IDLE cycle; returns just after the accept edge.
  task automatic accept(input int p, input string tag);
    #1;
    check({tag, "_ready"}, 64'(rdy(p)), 64'd1);
    check({tag, "_ready_other"}, 64'(rdy(1 - p)), 64'd0);
    @(negedge clk);
    if (p == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
    $display("accept port%0d %s", p, tag);
  endtask

  task automatic await_rsp(input int p, input int exp_lat, input string tag);
    int lat;
    lat = 1;
    while (!rv(p) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_other_rsp"}, 64'(rv(1 - p)), 64'd0);
  endtask

  task automatic release_rsp(input int p, input string tag);
    if (p == 0) bus.rsp0_ready = 1'b1;
    else        bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    check({tag, "_rsp_dropped"}, 64'(rv(p)), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_req(1, 1'b0, OP_THA, 32'd0, 32'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", 64'(bus.req0_ready), 64'd0);
    check("rst_rsp_valid", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'd0);
    check("rst_result", 64'(bus.rsp_result), 64'd0);
    check("rst_flags_dz", 64'({bus.rsp_carry, bus.rsp_sign, bus.rsp_zero, bus.rsp_dz}), 64'd0);
    check("rst_alu_com", 64'(bus.alu_com), 64'(OP_THA));
    check("rst_alu_in", 64'({bus.alu_in0, bus.alu_in1}), 64'd0);
    set_req(0, 1'b0, OP_THA, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Simultaneous requests straight after reset: port 0 first.
    set_req(0, 1'b1, OP_SUB, 32'd10, 32'd3);
    set_req(1, 1'b1, OP_MUL, 32'd6, 32'd7);
    accept(0, "sim0");
    #1 check("sim_exec_ready1", 64'(bus.req1_ready), 64'd0);
    await_rsp(0, 3, "sim0");
    check("sim0_result", 64'(bus.rsp_result), 64'd7);
    $display("rsp port0 result=%0d", bus.rsp_result);
    release_rsp(0, "sim0");
    accept(1, "sim1");
    await_rsp(1, 3, "sim1");
    check("sim1_result", 64'(bus.rsp_result), 64'd42);
    $display("rsp port1 result=%0d", bus.rsp_result);
    release_rsp(1, "sim1");

    // Fairness: prio back at 0, then strict alternation under contention.
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_req(1, 1'b1, OP_ADD, 32'd2, 32'd2);
    accept(0, "fair_a");
    set_req(0, 1'b1, OP_ADD, 32'd3, 32'd3);
    await_rsp(0, 3, "fair_a");
    check("fair_a_result", 64'(bus.rsp_result), 64'd2);
    release_rsp(0, "fair_a");
    accept(1, "fair_b");
    await_rsp(1, 3, "fair_b");
    check("fair_b_result", 64'(bus.rsp_result), 64'd4);
    release_rsp(1, "fair_b");
    accept(0, "fair_c");
    await_rsp(0, 3, "fair_c");
    check("fair_c_result", 64'(bus.rsp_result), 64'd6);
    release_rsp(0, "fair_c");

    // Lone ADD on port 0 while prio points at port 1.
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    accept(0, "add");
    await_rsp(0, 3, "add");
    check("add_result", 64'(bus.rsp_result), 64'd12);
    check("add_dz", 64'(bus.rsp_dz), 64'd0);
    $display("rsp port0 ADD result=%0d", bus.rsp_result);
    release_rsp(0, "add");

    // Compare flags, including sticky carry/zero across CGT.
    set_req(1, 1'b1, OP_CMP, 32'h1234, 32'h1234);
    accept(1, "cmp");
    await_rsp(1, 3, "cmp");
    check("cmp_result", 64'(bus.rsp_result), 64'h1234);
    check("cmp_flags", 64'({bus.rsp_carry, bus.rsp_sign, bus.rsp_zero}), 64'b001);
    release_rsp(1, "cmp");
    set_req(1, 1'b1, OP_CGT, 32'd3, 32'd9);
    accept(1, "cgt");
    await_rsp(1, 3, "cgt");
    check("cgt_flags", 64'({bus.rsp_carry, bus.rsp_sign, bus.rsp_zero}), 64'b011);
    release_rsp(1, "cgt");

    // Divide by zero never reaches the ALU.
    watch_com = 1'b1;
    set_req(0, 1'b1, OP_DIV, 32'd100, 32'd0);
    accept(0, "dz_div");
    await_rsp(0, 1, "dz_div");
    check("dz_div_result", 64'(bus.rsp_result), 64'd0);
    check("dz_div_dz", 64'(bus.rsp_dz), 64'd1);
    check("dz_div_flags", 64'({bus.rsp_carry, bus.rsp_sign, bus.rsp_zero}), 64'd0);
    release_rsp(0, "dz_div");
    set_req(1, 1'b1, OP_MOD, 32'd7, 32'd0);
    accept(1, "dz_mod");
    await_rsp(1, 1, "dz_mod");
    check("dz_mod_dz", 64'(bus.rsp_dz), 64'd1);
    release_rsp(1, "dz_mod");
    watch_com = 1'b0;
    check("dz_alu_com_idle", 64'(com_moved), 64'd0);
    check("dz_alu_flags_kept", 64'({alu_c, alu_s, alu_z}), 64'b011);
    set_req(0, 1'b1, OP_DIV, 32'd100, 32'd7);
    accept(0, "div");
    await_rsp(0, 3, "div");
    check("div_result", 64'(bus.rsp_result), 64'd14);
    check("div_dz", 64'(bus.rsp_dz), 64'd0);
    release_rsp(0, "div");

    // Response back-pressure holds result and blocks the other port.
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
    accept(0, "bp");
    set_req(1, 1'b1, OP_MUL, 32'd2, 32'd3);
    await_rsp(0, 3, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result_stable", 64'(bus.rsp_result), 64'd3);
      check("bp_ready1_low", 64'(bus.req1_ready), 64'd0);
      check("bp_rsp0_held", 64'(bus.rsp0_valid), 64'd1);
    end
    release_rsp(0, "bp");
    accept(1, "bp_grant");
    await_rsp(1, 3, "bp_grant");
    check("bp_grant_result", 64'(bus.rsp_result), 64'd6);
    release_rsp(1, "bp_grant");

    // Reset during FLAGS drops the transaction.
    set_req(0, 1'b1, OP_ADD, 32'd8, 32'd9);
    accept(0, "rst_mid");
    set_req(1, 1'b1, OP_MUL, 32'd4, 32'd4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_ready1", 64'(bus.req1_ready), 64'd0);
    check("rst_mid_rsp0", 64'(bus.rsp0_valid), 64'd0);
    check("rst_mid_result", 64'(bus.rsp_result), 64'd0);
    check("rst_mid_alu_com", 64'(bus.alu_com), 64'(OP_THA));
    check("rst_mid_alu_in0", 64'(bus.alu_in0), 64'd0);
    set_req(1, 1'b0, OP_THA, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid) seen = 1'b1;
    end
    check("rst_mid_no_rsp", 64'(seen), 64'd0);
    set_req(0, 1'b1, OP_ADD, 32'd8, 32'd9);
    accept(0, "reissue");
    await_rsp(0, 3, "reissue");
    check("reissue_result", 64'(bus.rsp_result), 64'd17);
    release_rsp(0, "reissue");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
